// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module : seq_det_pkg
// Brief  : State encodings and default pattern for the serial sequence detector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    localparam logic [15:0] c_DEFAULT_PAT = 16'h000B;

endpackage

`default_nettype wire

// File: rtl/seq_detector_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating event counter; a clear coinciding with an event yields 1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector.sv
// ============================================================================
// Module : seq_detector
// Brief  : Serial bit-pattern detector with loadable pattern and match counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_detector
    import seq_det_pkg::*;
#(
    parameter int              PAT_W     = 4,
    parameter int              CNT_W     = 8,
    parameter bit              OVERLAP   = 1'b1,
    parameter logic [15:0]     RESET_PAT = c_DEFAULT_PAT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             In,
    input  logic             PatLoad,
    input  logic [PAT_W-1:0] PatIn,
    input  logic             Clear,
    output logic             Out,
    output logic [CNT_W-1:0] MatchCount,
    output logic [1:0]       State
);

    localparam int               FILL_W      = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W);

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_out;

    state_t             w_state_nxt;
    logic [PAT_W-1:0]   w_pat_nxt;
    logic [PAT_W-1:0]   w_hist_nxt;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic               w_out_nxt;

    logic [PAT_W-1:0]   w_hist_sh;
    logic [FILL_W-1:0]  w_fill_sh;
    logic               w_accept;
    logic               w_match;

    assign w_hist_sh = {r_hist[PAT_W-2:0], In};
    assign w_fill_sh = (r_fill == c_FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    assign w_accept  = Enable && !PatLoad && (r_state != ST_BAD);
    assign w_match   = w_accept && (w_fill_sh == c_FILL_FULL) && (w_hist_sh == r_pat);

    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_out_nxt   = 1'b0;
        if (PatLoad) begin
            w_pat_nxt   = PatIn;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_BAD) begin
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = ST_IDLE;
        end else if (Enable) begin
            w_out_nxt = w_match;
            // Non-overlapping mode restarts history on the very edge that matches.
            if (w_match && !OVERLAP) begin
                w_hist_nxt  = '0;
                w_fill_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end else begin
                w_hist_nxt  = w_hist_sh;
                w_fill_nxt  = w_fill_sh;
                w_state_nxt = (w_fill_sh == c_FILL_FULL) ? ST_ARMED : ST_FILL;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pat   <= RESET_PAT[PAT_W-1:0];
            r_hist  <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_out   <= w_out_nxt;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (w_match),
        .clr   (Clear),
        .count (MatchCount)
    );

    assign Out   = r_out;
    assign State = r_state;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector.sv
// ============================================================================
// Module : tb_seq_detector
// Brief  : Directed vector bench for seq_detector (overlap, non-overlap, saturation).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector;

    logic       Clock;
    logic       Reset;
    logic       Enable;
    logic       In;
    logic       PatLoad;
    logic [3:0] PatIn;
    logic       Clear;

    logic       o_ov, o_no, o_sat;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_sat;
    logic [1:0] s_ov, s_no, s_sat;

    int total = 0;
    int bad   = 0;

    seq_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b1)) u_ov (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .In(In), .PatLoad(PatLoad),
        .PatIn(PatIn), .Clear(Clear), .Out(o_ov), .MatchCount(c_ov), .State(s_ov));

    seq_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b0)) u_no (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .In(In), .PatLoad(PatLoad),
        .PatIn(PatIn), .Clear(Clear), .Out(o_no), .MatchCount(c_no), .State(s_no));

    seq_detector #(.PAT_W(4), .CNT_W(2), .OVERLAP(1'b1)) u_sat (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .In(In), .PatLoad(PatLoad),
        .PatIn(PatIn), .Clear(Clear), .Out(o_sat), .MatchCount(c_sat), .State(s_sat));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct packed {
        logic       en;
        logic       in;
        logic       pl;
        logic [3:0] pi;
        logic       clr;
        logic       o_ov;
        logic [1:0] s_ov;
        logic [7:0] c_ov;
        logic       o_no;
        logic [1:0] s_no;
        logic [7:0] c_no;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic in, input logic pl,
                        input logic [3:0] pi, input logic clr);
        Enable  = en;
        In      = in;
        PatLoad = pl;
        PatIn   = pi;
        Clear   = clr;
        @(posedge Clock);
        #1;
    endtask

    task automatic async_reset();
        Reset = 1'b1;
        #2;
        chk("async_rst_state", 32'(s_ov), 32'd0);
        chk("async_rst_out",   32'(o_ov), 32'd0);
        chk("async_rst_cnt",   32'(c_ov), 32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        int   pulses;
        logic [15:0] stream;

        Reset = 1'b1; Enable = 1'b0; In = 1'b0; PatLoad = 1'b0; PatIn = 4'h0; Clear = 1'b0;

        //            en  in  pl  pi    clr | o s  cnt  | o s  cnt   (OVERLAP=1 | OVERLAP=0)
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd1,8'd0, 1'b0,2'd1,8'd0});
        tbl.push_back('{1'b1,1'b0,1'b0,4'h0,1'b0, 1'b0,2'd1,8'd0, 1'b0,2'd1,8'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd1,8'd0, 1'b0,2'd1,8'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b1,2'd2,8'd1, 1'b1,2'd0,8'd1});
        tbl.push_back('{1'b1,1'b0,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd1, 1'b0,2'd1,8'd1});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd1, 1'b0,2'd1,8'd1});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b1,2'd2,8'd2, 1'b0,2'd1,8'd1});
        // Enable gaps between bits, then Clear on the completing edge.
        tbl.push_back('{1'b1,1'b0,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd2, 1'b0,2'd2,8'd1});
        tbl.push_back('{1'b0,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd2, 1'b0,2'd2,8'd1});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd2, 1'b0,2'd2,8'd1});
        tbl.push_back('{1'b0,1'b0,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd2, 1'b0,2'd2,8'd1});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b1, 1'b1,2'd2,8'd1, 1'b1,2'd0,8'd1});
        tbl.push_back('{1'b0,1'b0,1'b0,4'h0,1'b1, 1'b0,2'd2,8'd0, 1'b0,2'd0,8'd0});
        // Load 0110 while ARMED; the In bit on that edge is dropped.
        tbl.push_back('{1'b1,1'b1,1'b1,4'h6,1'b0, 1'b0,2'd0,8'd0, 1'b0,2'd0,8'd0});
        tbl.push_back('{1'b1,1'b0,1'b0,4'h0,1'b0, 1'b0,2'd1,8'd0, 1'b0,2'd1,8'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd1,8'd0, 1'b0,2'd1,8'd0});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd1,8'd0, 1'b0,2'd1,8'd0});
        tbl.push_back('{1'b1,1'b0,1'b0,4'h0,1'b0, 1'b1,2'd2,8'd1, 1'b1,2'd0,8'd1});
        tbl.push_back('{1'b1,1'b1,1'b0,4'h0,1'b0, 1'b0,2'd2,8'd1, 1'b0,2'd1,8'd1});

        #2;
        chk("rst_state", 32'(s_ov), 32'd0);
        chk("rst_out",   32'(o_ov), 32'd0);
        chk("rst_cnt",   32'(c_ov), 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].in, tbl[i].pl, tbl[i].pi, tbl[i].clr);
            chk($sformatf("v%0d_ov_out", i),   32'(o_ov), 32'(tbl[i].o_ov));
            chk($sformatf("v%0d_ov_state", i), 32'(s_ov), 32'(tbl[i].s_ov));
            chk($sformatf("v%0d_ov_cnt", i),   32'(c_ov), 32'(tbl[i].c_ov));
            chk($sformatf("v%0d_no_out", i),   32'(o_no), 32'(tbl[i].o_no));
            chk($sformatf("v%0d_no_state", i), 32'(s_no), 32'(tbl[i].s_no));
            chk($sformatf("v%0d_no_cnt", i),   32'(c_no), 32'(tbl[i].c_no));
        end

        // Partial progress is discarded by a mid-pattern reset.
        async_reset();
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        chk("mid_pre_state", 32'(s_ov), 32'd1);
        async_reset();
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        chk("mid_post_out",   32'(o_ov), 32'd0);
        chk("mid_post_state", 32'(s_ov), 32'd1);
        chk("mid_post_cnt",   32'(c_ov), 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        chk("mid_bit3_out", 32'(o_ov), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        chk("mid_bit4_out", 32'(o_ov), 32'd1);

        // Saturation with a 2-bit counter: five overlapping matches.
        async_reset();
        stream = 16'b1011011011011011;
        pulses = 0;
        for (int i = 15; i >= 0; i--) begin
            step(1'b1, stream[i], 1'b0, 4'h0, 1'b0);
            if (o_sat) pulses++;
        end
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("sat_out_after_idle", 32'(o_sat), 32'd0);
        chk("sat_pulses", 32'(pulses), 32'd5);
        chk("sat_cnt",    32'(c_sat),  32'd3);
        chk("sat_ref_cnt", 32'(c_ov),  32'd5);
        chk("sat_state",  32'(s_sat),  32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, 8, match-counter width; legal range 1..16.
REQ-003 Parameter OVERLAP, 1, 1 = overlapping matches allowed, 0 = history restarts after each match.
REQ-004 Parameter RESET_PAT, 4'b1011 (zero-extended or truncated to PAT_W), pattern value after reset.
REQ-005 Clock  input  1  clock; all state updates on the rising edge.
REQ-006 Reset  input  1  reset, asynchronous, active-high.
REQ-007 Enable  input  1  In is sampled only on edges where Enable=1.
REQ-008 In  input  1  serial data bit.
REQ-009 PatLoad  input  1  load PatIn as the new pattern.
REQ-010 PatIn  input  PAT_W  new pattern; MSB is the first bit received.
REQ-011 Clear  input  1  synchronous clear of MatchCount.
REQ-012 Out  output  1  registered one-cycle match pulse.
REQ-013 MatchCount  output  CNT_W  saturating count of matches.
REQ-014 State  output  2  current FSM state: IDLE=0, FILL=1, ARMED=2.

Function
REQ-015 Internal registers: pattern reg (PAT_W), history shift reg (PAT_W), fill count (clog2(PAT_W+1)), state, Out, MatchCount.
REQ-016 Accepted bit (Enable=1, PatLoad=0): history shifts left and In enters the LSB; fill increments and saturates at PAT_W.
REQ-017 Match condition: fill-after-shift == PAT_W and history-after-shift == pattern reg.
REQ-018 Out is 1 in the cycle following the edge that accepts the completing bit, for exactly one cycle; otherwise 0.
REQ-019 State transitions: IDLE -> FILL on the first accepted bit; FILL -> ARMED when fill reaches PAT_W; ARMED holds while OVERLAP=1.
REQ-020 OVERLAP=0 and a match: history and fill clear, State -> IDLE on the same edge that sets Out.
REQ-021 Enable=0: history, fill, State and pattern hold; Out is 0.
REQ-022 PatLoad=1: pattern reg <= PatIn; history and fill clear; State -> IDLE; Out 0; PatLoad has priority over Enable, and In is not accepted on that edge.
REQ-023 MatchCount increments by 1 per match and saturates at 2^CNT_W-1; no wrap-around.
REQ-024 Clear and a match on the same edge: MatchCount = 1.
REQ-025 Clear alone: MatchCount = 0; FSM, history and pattern are unaffected.
REQ-026 Unused State encoding 3: next state IDLE, Out 0, history and fill cleared.

Reset
REQ-027 Reset=1 forces, without waiting for a clock edge: State=IDLE, Out=0, MatchCount=0, history=0, fill=0, pattern=RESET_PAT.
REQ-028 Reset asserted mid-pattern discards partial progress; the first bit accepted after release counts as bit 1.

Structure
REQ-029 Package seq_det_pkg holds the state encodings (IDLE, FILL, ARMED) and the default pattern constant.
REQ-030 Sub-module sat_counter (parameter CNT_W; inputs inc, clr; output count) implements MatchCount, including REQ-023 and REQ-024.
REQ-031 Next-state and next-Out logic are combinational; the FSM state, Out and all internal registers update in a single clocked block.

Verification (PAT_W=4, RESET_PAT=1011, CNT_W=8 unless stated)
REQ-032 OVERLAP=1, stream 1,0,1,1,0,1,1 with Enable=1 -> Out pulses after bits 4 and 7; MatchCount=2; State=ARMED.
REQ-033 OVERLAP=0, same stream -> Out pulses after bit 4 only; MatchCount=1; State=FILL after bit 7.
REQ-034 Stream 1,0,1 then Reset pulse, then 1 -> no Out pulse; State=FILL; MatchCount=0.
REQ-035 In ARMED, PatLoad with PatIn=0110 -> State=IDLE and Out=0 next cycle; then stream 0,1,1,0 -> one Out pulse; MatchCount increments by 1.
REQ-036 CNT_W=2, OVERLAP=1, stream 1011011011011011 (5 matches) -> MatchCount=3 (saturated); Out still pulses 5 times.
REQ-037 Clear asserted on the edge that accepts a completing bit -> MatchCount=1; Enable toggled low between bits -> matches unaffected by the gaps.
